// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state encoding, register map and CTRL bit positions for pwm_ctrl.
package pwm_pkg;
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    S_CORE    = 4'd1,
    S_CNT     = 4'd2,
    S_OUT     = 4'd3,
    RUN       = 4'd4,
    STOP_WAIT = 4'd5,
    D_OUT     = 4'd6,
    D_CNT     = 4'd7,
    D_CORE    = 4'd8
  } state_t;
  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PERIOD = 2'd1;
  localparam logic [1:0] A_DUTY   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;
  localparam int C_START = 0;
  localparam int C_STOP  = 1;
  localparam int C_SEL   = 2;
  localparam int C_OUT   = 3;
endpackage

// File: rtl/pwm_period_tracker.sv
// pwm_period_tracker: mirrors the pwm_core counter (0..period-1) and flags the wrap cycle.
module pwm_period_tracker #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_period,
  output logic         o_tick
);
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] r_cnt;
  // >= rather than == keeps the counter from running away if the period ever shrinks under it
  assign o_tick = i_en && (r_cnt >= i_period - ONE);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + ONE;
endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: bus-mapped shadow PERIOD/DUTY with boundary commits and pwm_core enable sequencing.
// Optional soft-start duty ramp is enabled by defining PWM_CTRL_RAMP_EN.
module pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int W         = 16,
  parameter int RAMP_STEP = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr_en,
  input  logic         i_rd_en,
  input  logic [1:0]   i_addr,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic [W-1:0] o_period_reg,
  output logic [W-1:0] o_duty_reg,
  output logic         o_duty_sel,
  output logic         o_pwm_core_EN,
  output logic         o_main_counter_EN,
  output logic         o_pwm_EN,
  output logic         o_period_tick,
  output logic         o_busy,
  output logic         o_err
);
`ifdef PWM_CTRL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  state_t       r_state, w_nxt;
  logic [W-1:0] r_sh_period, r_sh_duty, r_period, r_target, r_ramp, r_rdata;
  logic         r_sh_sel, r_out_en, r_duty_sel, r_pending, r_err, r_ramping;
  logic         w_wr_ctrl, w_wr_per, w_wr_duty, w_wr_stat, w_start, w_stop;
  logic         w_per_bad, w_sel_chg, w_commit, w_clamp, w_run_entry;
  logic [W:0]   w_ramp_sum;
  logic [W-1:0] w_ramp_nxt, w_rd;
  assign w_wr_ctrl   = i_wr_en && i_addr == A_CTRL;
  assign w_wr_per    = i_wr_en && i_addr == A_PERIOD;
  assign w_wr_duty   = i_wr_en && i_addr == A_DUTY;
  assign w_wr_stat   = i_wr_en && i_addr == A_STATUS;
  assign w_start     = w_wr_ctrl && i_wdata[C_START];
  assign w_stop      = w_wr_ctrl && i_wdata[C_STOP];
  assign w_per_bad   = w_wr_per && i_wdata == '0;
  assign w_sel_chg   = w_wr_ctrl && i_wdata[C_SEL] != r_sh_sel;
  assign w_commit    = r_pending && (r_state == IDLE || o_period_tick);
  assign w_clamp     = r_sh_duty > r_sh_period;
  assign w_run_entry = r_state == S_OUT && w_nxt == RUN;
  assign w_ramp_sum  = {1'b0, r_ramp} + (W+1)'(RAMP_STEP);
  assign w_ramp_nxt  = w_ramp_sum > {1'b0, r_target} ? r_target : w_ramp_sum[W-1:0];
  assign w_rd = i_addr == A_STATUS ? W'({r_ramping, 1'b0, r_err, r_pending, r_state}) :
                i_addr == A_DUTY   ? r_sh_duty :
                i_addr == A_PERIOD ? r_sh_period : W'({r_out_en, r_sh_sel, 2'b00});
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  // stop aborts a partial power-up through the mirror-image power-down state
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:      w_nxt = w_start && !w_stop ? S_CORE : IDLE;
      S_CORE:    w_nxt = w_stop ? D_CORE : S_CNT;
      S_CNT:     w_nxt = w_stop ? D_CNT : S_OUT;
      S_OUT:     w_nxt = w_stop ? D_OUT : RUN;
      RUN:       w_nxt = w_stop ? STOP_WAIT : RUN;
      STOP_WAIT: w_nxt = o_period_tick ? D_OUT : STOP_WAIT;
      D_OUT:     w_nxt = D_CNT;
      D_CNT:     w_nxt = D_CORE;
      default:   w_nxt = IDLE;
    endcase
  end
  assign o_pwm_core_EN     = r_state inside {S_CORE, S_CNT, S_OUT, RUN, STOP_WAIT, D_OUT, D_CNT};
  assign o_main_counter_EN = r_state inside {S_CNT, S_OUT, RUN, STOP_WAIT, D_OUT};
  assign o_pwm_EN          = r_out_en && r_state inside {S_OUT, RUN, STOP_WAIT};
  assign o_busy            = r_state != IDLE;
  assign o_err             = r_err;
  assign o_period_reg      = r_period;
  assign o_duty_sel        = r_duty_sel;
  assign o_duty_reg        = r_ramping ? r_ramp : r_target;
  assign o_rdata           = r_rdata;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sh_period <= '0;
      r_sh_duty   <= '0;
      r_sh_sel    <= 1'b0;
      r_out_en    <= 1'b0;
      r_period    <= '0;
      r_target    <= '0;
      r_duty_sel  <= 1'b0;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_ramp      <= '0;
      r_ramping   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_wr_per && !w_per_bad) r_sh_period <= i_wdata;
      if (w_wr_duty) r_sh_duty <= i_wdata;
      if (w_wr_ctrl) begin
        r_sh_sel <= i_wdata[C_SEL];
        r_out_en <= i_wdata[C_OUT];
      end
      if (w_commit) begin
        r_period   <= r_sh_period;
        r_target   <= w_clamp ? r_sh_period : r_sh_duty;
        r_duty_sel <= r_sh_sel;
      end
      // a write in the commit cycle re-arms pending so it lands at the next boundary
      r_pending <= (r_pending && !w_commit) || (w_wr_per && !w_per_bad) || w_wr_duty || w_sel_chg;
      r_err     <= (r_err && !w_wr_stat) || w_per_bad || (w_commit && w_clamp);
      if (w_run_entry) begin
        r_ramp    <= '0;
        r_ramping <= RAMP;
      end else if (r_state == IDLE) r_ramping <= 1'b0;
      else if (r_ramping && o_period_tick) begin
        r_ramp    <= w_ramp_nxt;
        r_ramping <= w_ramp_nxt != r_target;
      end
      if (i_rd_en) r_rdata <= w_rd;
    end
  pwm_period_tracker #(.W(W)) u_trk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (o_main_counter_EN),
    .i_clr   (r_state == D_CNT),
    .i_period(r_period),
    .o_tick  (o_period_tick)
  );
endmodule
